int_div_seq: RTL

Sequential restoring integer divider for the integer ALU. It accepts one WIDTH-bit dividend/divisor pair through a valid/ready handshake and produces one quotient bit per cycle. Each cycle performs a trial subtraction that is split into two half-width chunks with carry-select borrow. The result is returned through a second valid/ready handshake. It sits beside the combinational add/sub units and serves the multi-cycle divide/remainder opcodes.

---
 rtl/int_div_pkg.sv | 19 +
 rtl/int_div_seq_div_step.sv | 40 ++++
 rtl/int_div_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/int_div_pkg.sv
// Shared definitions for the sequential integer divider.
//   - state_t      : divider FSM states
//   - DEF_WIDTH    : default operand/result width
//   - cnt_width()  : width of the iteration counter for a given operand width
package int_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/int_div_seq_div_step.sv
// div_step: combinational trial subtractor for one restoring-divide step.
// Computes partial - divisor as two HALF-bit chunks. The high chunk is
// evaluated for both borrow-in values and the low-chunk borrow selects one.
//   partial  in  WIDTH  shifted partial remainder
//   divisor  in  WIDTH  divisor magnitude
//   diff     out WIDTH  partial - divisor (mod 2^WIDTH)
//   borrow   out 1      1 when partial < divisor
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] partial,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int HALF = WIDTH / 2;

    logic [HALF:0] lo_res;
    logic [HALF:0] hi_res_b0;
    logic [HALF:0] hi_res_b1;

    // The extra top bit of each (HALF+1)-bit result is the chunk's borrow-out.
    assign lo_res    = {1'b0, partial[HALF-1:0]} - {1'b0, divisor[HALF-1:0]};
    assign hi_res_b0 = {1'b0, partial[WIDTH-1:HALF]} - {1'b0, divisor[WIDTH-1:HALF]};
    assign hi_res_b1 = {1'b0, partial[WIDTH-1:HALF]} - {1'b0, divisor[WIDTH-1:HALF]}
                       - {{HALF{1'b0}}, 1'b1};

    always_comb begin
        diff[HALF-1:0] = lo_res[HALF-1:0];
        if (lo_res[HALF]) begin
            diff[WIDTH-1:HALF] = hi_res_b1[HALF-1:0];
            borrow             = hi_res_b1[HALF];
        end else begin
            diff[WIDTH-1:HALF] = hi_res_b0[HALF-1:0];
            borrow             = hi_res_b0[HALF];
        end
    end

endmodule

// File: rtl/int_div_seq.sv
// int_div_seq: sequential restoring integer divider, one quotient bit per cycle.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; the producer holds data and valid stable until that edge, and
// ready never depends combinationally on valid.
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        operand handshake (in_ready high only in IDLE)
//   is_signed                1 = two's-complement divide
//   dividend, divisor        operands
//   out_valid/out_ready      result handshake (out_valid high only in DONE)
//   quotient, remainder      registered results
//   div_by_zero              divisor was zero for this result
//   dbg_state                current FSM state, for observation
module int_div_seq
    import int_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] q_shift_q;
    logic [WIDTH-1:0] dvs_mag_q;
    logic             neg_q_q;
    logic             neg_r_q;

    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] diff;
    logic             step_borrow;
    logic             borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;
    logic             divisor_zero;

    assign divisor_zero = (divisor == '0);

    assign partial = {rem_q[WIDTH-2:0], q_shift_q[WIDTH-1]};

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial (partial),
        .divisor (dvs_mag_q),
        .diff    (diff),
        .borrow  (step_borrow)
    );

    // The bit shifted out of rem is the 33rd bit of the true partial
    // remainder; when it is set the partial exceeds any divisor, so the
    // subtraction always succeeds and the low WIDTH bits of diff are exact.
    assign borrow   = step_borrow & ~rem_q[WIDTH-1];
    assign rem_next = borrow ? partial : diff;
    assign q_next   = {q_shift_q[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = divisor_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            q_shift_q   <= '0;
            dvs_mag_q   <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        neg_q_q   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r_q   <= is_signed & dividend[WIDTH-1];
                        q_shift_q <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
                        dvs_mag_q <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
                        rem_q     <= '0;
                        cnt_q     <= CW'(WIDTH - 1);
                        if (divisor_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem_q     <= rem_next;
                    q_shift_q <= q_next;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        // Last step: apply signs while loading the output registers.
                        quotient  <= neg_q_q ? -q_next : q_next;
                        remainder <= neg_r_q ? -rem_next : rem_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
